// File: rtl/seq_detect_param.sv
// seq_detect_param: Moore serial detector for a runtime-loadable PAT_W-bit
// pattern (MSB received first), with elaboration-time overlap mode and a
// saturating match counter. y_out is a registered one-cycle match pulse.
//
// Input qualifier: d_in is consumed only on a rising edge where en=1 and
// pat_load=0; with en=0 the history is frozen, so idle gaps are transparent.
module seq_detect_param #(
    parameter int               PAT_W   = 5,
    parameter logic [PAT_W-1:0] PATTERN = 5'b10101,
    parameter bit               OVERLAP = 1'b1,
    parameter int               CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             d_in,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_in,
    input  logic             cnt_clr,
    output logic             y_out,
    output logic [CNT_W-1:0] match_cnt,
    output logic [PAT_W-1:0] pat_cur
);

    localparam int               FILL_W   = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic [PAT_W-1:0]  hist_q, hist_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [PAT_W-1:0]  pat_q, pat_d;
    logic              y_q, y_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [PAT_W-1:0]  shifted;
    logic [FILL_W-1:0] fill_next;
    logic              match;

    // Candidate history and match test against the pattern active before the edge.
    always_comb begin
        shifted   = {hist_q[PAT_W-2:0], d_in};
        fill_next = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_W'(1);
        match     = en && !pat_load && (fill_next == FILL_FULL) && (shifted == pat_q);
    end

    // Next-state: pattern load wins over bit consumption; counter is independent.
    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        pat_d  = pat_q;
        y_d    = match;
        cnt_d  = cnt_q;

        if (pat_load) begin
            // A new pattern restarts detection; any bit on this edge is dropped.
            pat_d  = pat_in;
            hist_d = '0;
            fill_d = '0;
        end else if (en) begin
            hist_d = shifted;
            // Non-overlapping mode consumes the matched bits by emptying the history.
            fill_d = (match && !OVERLAP) ? '0 : fill_next;
        end

        if (cnt_clr) begin
            cnt_d = match ? CNT_W'(1) : '0;
        end else if (match && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State register with synchronous reset overriding every other control.
    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q <= '0;
            fill_q <= '0;
            pat_q  <= PATTERN;
            y_q    <= 1'b0;
            cnt_q  <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
            pat_q  <= pat_d;
            y_q    <= y_d;
            cnt_q  <= cnt_d;
        end
    end

    assign y_out     = y_q;
    assign match_cnt = cnt_q;
    assign pat_cur   = pat_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param: four instances share one clock.
//   u_ov1 / u_ov0 : PAT_W=5, 10101, overlap on / off, driven by the same a_* stimulus
//   u_sat         : PAT_W=2, 11, CNT_W=2, counter saturation and clear
//   u_wide        : PAT_W=16, A5C3, random prefixes against a shift-register model
module tb_seq_detect_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // a_* stimulus, shared by both 5-bit instances
    logic       a_rst = 1'b0, a_en = 1'b0, a_d = 1'b0, a_load = 1'b0, a_clr = 1'b0;
    logic [4:0] a_pat_in = '0;
    logic       y0, y1;
    logic [7:0] cnt0, cnt1;
    logic [4:0] pat0, pat1;

    // b_* stimulus for the saturation instance
    logic       b_rst = 1'b0, b_en = 1'b0, b_d = 1'b0, b_load = 1'b0, b_clr = 1'b0;
    logic [1:0] b_pat_in = '0;
    logic       y2;
    logic [1:0] cnt2;
    logic [1:0] pat2;

    // c_* stimulus for the wide instance
    logic        c_rst = 1'b0, c_en = 1'b0, c_d = 1'b0;
    logic        y3;
    logic [7:0]  cnt3;
    logic [15:0] pat3;

    logic exp_q[$];

    seq_detect_param #(.PAT_W(5), .PATTERN(5'b10101), .OVERLAP(1'b1), .CNT_W(8)) u_ov1 (
        .clk(clk), .rst(a_rst), .en(a_en), .d_in(a_d), .pat_load(a_load),
        .pat_in(a_pat_in), .cnt_clr(a_clr), .y_out(y0), .match_cnt(cnt0), .pat_cur(pat0));

    seq_detect_param #(.PAT_W(5), .PATTERN(5'b10101), .OVERLAP(1'b0), .CNT_W(8)) u_ov0 (
        .clk(clk), .rst(a_rst), .en(a_en), .d_in(a_d), .pat_load(a_load),
        .pat_in(a_pat_in), .cnt_clr(a_clr), .y_out(y1), .match_cnt(cnt1), .pat_cur(pat1));

    seq_detect_param #(.PAT_W(2), .PATTERN(2'b11), .OVERLAP(1'b1), .CNT_W(2)) u_sat (
        .clk(clk), .rst(b_rst), .en(b_en), .d_in(b_d), .pat_load(b_load),
        .pat_in(b_pat_in), .cnt_clr(b_clr), .y_out(y2), .match_cnt(cnt2), .pat_cur(pat2));

    seq_detect_param #(.PAT_W(16), .PATTERN(16'hA5C3), .OVERLAP(1'b1), .CNT_W(8)) u_wide (
        .clk(clk), .rst(c_rst), .en(c_en), .d_in(c_d), .pat_load(1'b0),
        .pat_in(16'h0000), .cnt_clr(1'b0), .y_out(y3), .match_cnt(cnt3), .pat_cur(pat3));

    // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic a_reset();
        a_rst = 1'b1;
        step();
        a_rst = 1'b0;
    endtask

    // Send n bits (MSB first) to both 5-bit instances, checking y_out after each.
    task automatic run_a(input logic [15:0] bits, input logic [15:0] e0, input logic [15:0] e1,
                         input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            a_en = 1'b1;
            a_d  = bits[n-1-i];
            step();
            a_en = 1'b0;
            check($sformatf("%s ov1 y b%0d", tag, i + 1), 32'(y0), 32'(e0[n-1-i]));
            check($sformatf("%s ov0 y b%0d", tag, i + 1), 32'(y1), 32'(e1[n-1-i]));
        end
    endtask

    task automatic a_cnt(input string tag, input int e0, input int e1);
        check({tag, " ov1 cnt"}, 32'(cnt0), e0);
        check({tag, " ov0 cnt"}, 32'(cnt1), e1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] prefix;
        logic [31:0] stream;
        logic [15:0] sr;
        logic        exp_y;
        int          n_exp;

        // ---- reset state of every instance
        a_rst = 1'b1; b_rst = 1'b1; c_rst = 1'b1;
        step();
        a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;
        check("rst ov1 y",   32'(y0),   0);
        check("rst ov1 cnt", 32'(cnt0), 0);
        check("rst ov1 pat", 32'(pat0), 32'h15);
        check("rst ov0 pat", 32'(pat1), 32'h15);
        check("rst sat pat", 32'(pat2), 32'h3);
        check("rst wide pat", 32'(pat3), 32'hA5C3);

        // ---- overlap on/off: 1010101
        run_a(16'b1010101, 16'b0000101, 16'b0000100, 7, "ovl7");
        a_cnt("ovl7", 2, 1);

        // ---- 1010110101 matches after bits 5 and 10 in both modes
        a_reset();
        run_a(16'b1010110101, 16'b0000100001, 16'b0000100001, 10, "ovl10");
        a_cnt("ovl10", 2, 2);

        // ---- en gap of 3 cycles between bits 2 and 3
        a_reset();
        run_a(16'b10, 16'b00, 16'b00, 2, "gap pre");
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("gap idle%0d y", i), 32'({y0, y1}), 0);
        end
        run_a(16'b101, 16'b001, 16'b001, 3, "gap post");
        step();
        check("gap single pulse", 32'({y0, y1}), 0);
        a_cnt("gap", 1, 1);

        // ---- reset after bit 3 discards progress
        a_reset();
        run_a(16'b101, 16'b000, 16'b000, 3, "midrst pre");
        a_reset();
        check("midrst y", 32'({y0, y1}), 0);
        run_a(16'b01, 16'b00, 16'b00, 2, "midrst post");
        a_cnt("midrst", 0, 0);

        // ---- runtime load: same-edge d_in=1 is discarded
        run_a(16'b110, 16'b000, 16'b000, 3, "load pre");
        a_load = 1'b1; a_pat_in = 5'b01101; a_en = 1'b1; a_d = 1'b1;
        step();
        a_load = 1'b0; a_en = 1'b0;
        check("load y", 32'({y0, y1}), 0);
        check("load ov1 pat", 32'(pat0), 32'h0D);
        check("load ov0 pat", 32'(pat1), 32'h0D);
        run_a(16'b01101, 16'b00001, 16'b00001, 5, "load match");
        a_cnt("load", 1, 1);
        // a second load with d_in=0 kept would complete 01101 after 1101
        a_load = 1'b1; a_en = 1'b1; a_d = 1'b0;
        step();
        a_load = 1'b0; a_en = 1'b0;
        a_cnt("reload keeps cnt", 1, 1);
        run_a(16'b1101, 16'b0000, 16'b0000, 4, "reload short");
        a_reset();
        check("load rst ov1 pat", 32'(pat0), 32'h15);
        check("load rst ov0 pat", 32'(pat1), 32'h15);
        a_cnt("load rst", 0, 0);

        // ---- saturation: PAT_W=2, pattern 11, CNT_W=2
        for (int i = 0; i < 6; i++) begin
            b_en = 1'b1; b_d = 1'b1;
            step();
            check($sformatf("sat y c%0d", i + 1), 32'(y2), (i == 0) ? 0 : 1);
            check($sformatf("sat cnt c%0d", i + 1), 32'(cnt2), (i > 3) ? 3 : i);
        end
        b_clr = 1'b1;
        step();
        check("clr+match y", 32'(y2), 1);
        check("clr+match cnt", 32'(cnt2), 1);
        b_en = 1'b0;
        step();
        check("clr idle y", 32'(y2), 0);
        check("clr idle cnt", 32'(cnt2), 0);
        b_clr = 1'b0; b_en = 1'b1;
        step();
        check("post clr cnt", 32'(cnt2), 1);
        b_en = 1'b0;
        b_rst = 1'b1; b_load = 1'b1; b_pat_in = 2'b01;
        step();
        b_rst = 1'b0; b_load = 1'b0;
        check("rst over load pat", 32'(pat2), 32'h3);
        check("rst over load cnt", 32'(cnt2), 0);

        // ---- wide pattern: random prefixes, then one prefix that is A5C3 itself
        for (int t = 0; t < 3; t++) begin
            c_rst = 1'b1;
            step();
            c_rst = 1'b0;
            prefix = (t == 2) ? 16'hA5C3 : 16'($urandom_range(0, 65535));
            stream = {prefix, 16'hA5C3};
            sr     = '0;
            n_exp  = 0;
            for (int i = 0; i < 32; i++) begin
                sr    = {sr[14:0], stream[31-i]};
                exp_y = (i >= 15) && (sr == 16'hA5C3);
                if (exp_y) n_exp++;
                exp_q.push_back(exp_y);
                c_en = 1'b1; c_d = stream[31-i];
                step();
                c_en = 1'b0;
                check($sformatf("wide t%0d y b%0d", t, i + 1), 32'(y3), 32'(exp_q.pop_front()));
            end
            check($sformatf("wide t%0d cnt", t), 32'(cnt3), n_exp);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/seq_detect_param.md
# seq_detect_param

Parametrised Moore-style serial sequence detector. It watches a 1-bit serial stream for a PAT_W-bit pattern, with overlap behaviour selected at elaboration time. The pattern can be replaced at runtime, and the block keeps a saturating count of matches. It sits on the serial input path of the state-machine library and is the general form of the fixed-pattern detectors, intended to replace hand-coded per-pattern FSMs.

## Interface
- PAT_W, 5: pattern length in bits; legal range 2..32.
- PATTERN, 5'b10101: reset and default pattern. The MSB is the first bit received.
- OVERLAP, 1: 1 = overlapping detection, 0 = non-overlapping (matched bits are consumed).
- CNT_W, 8: width of the match counter.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  qualifies d_in; a bit is consumed only on a clock edge where en=1.
- d_in  in  1  serial data bit.
- pat_load  in  1  loads pat_in as the active pattern on this edge.
- pat_in  in  PAT_W  new pattern, MSB first.
- cnt_clr  in  1  clears match_cnt on this edge.
- y_out  out  1  registered match flag: high for the cycle after the edge that consumed the final pattern bit.
- match_cnt  out  CNT_W  number of matches since reset or clear; saturating.
- pat_cur  out  PAT_W  currently active pattern.

## Operation
- Internal state:
  - hist[PAT_W-1:0]: received-bit history.
  - fill: 0..PAT_W, number of valid history bits.
  - pat: the active pattern.
- Shift on consume: shifted = {hist[PAT_W-2:0], d_in}. fill_next = min(fill+1, PAT_W).
- Match condition: en=1, fill_next==PAT_W and shifted==pat. Evaluate it against the pattern active before the edge.
- On a consumed bit: hist <= shifted.
  - If there is a match and OVERLAP=0: fill <= 0.
  - Otherwise: fill <= fill_next.
- OVERLAP=1 allows back-to-back matches, e.g. every cycle for an all-ones pattern.
- y_out <= match on every edge. It is therefore 0 on any edge with en=0, pat_load=1, or no match. y_out depends only on registered state, with no combinational path from d_in.
- match_cnt increments by 1 on a match. It holds at 2^CNT_W-1 and never wraps.
- Edge priority:
  1. rst
  2. pat_load
  3. en/d_in
- pat_load=1: pat <= pat_in, hist <= 0, fill <= 0, y_out <= 0. Any d_in on the same edge is discarded, even if en=1. match_cnt is unaffected.
- cnt_clr=1: match_cnt <= 0. If a match occurs on the same edge, match_cnt <= 1 and y_out still pulses. cnt_clr is independent of pat_load.
- en=0: hist, fill and pat hold. match_cnt holds unless cnt_clr=1.
- Reset (rst=1 at an edge): pat <= PATTERN, hist <= 0, fill <= 0, y_out <= 0, match_cnt <= 0, pat_cur = PATTERN. Reset mid-sequence discards all partial progress, so a full PAT_W bits is required afterwards. Reset overrides pat_load, cnt_clr and en on the same edge.

## Timing
- Latency: y_out rises exactly 1 cycle after the clock edge that consumes the last pattern bit and stays high for 1 cycle per match.
- The first match after reset or a pattern load needs at least PAT_W consumed bits.
- match_cnt updates on the same edge that sets y_out.
- pat_cur reflects a load 1 cycle after the pat_load edge.
- Gaps with en=0 between bits are transparent: the sequence continues across them.
- Inputs are sampled only at rising clk edges. No minimum en duty is required.

## Test plan
- Overlap on: PATTERN=10101, OVERLAP=1, en=1, stream 1,0,1,0,1,0,1. Required: y_out high after bits 5 and 7; match_cnt=2.
- Overlap off: same stream, OVERLAP=0. Required: y_out high after bit 5 only; match_cnt=1. Then stream 1010110101 gives matches after bits 5 and 10 in both modes.
- en gaps and mid-sequence reset:
  - Stream 10101 with en=0 inserted for 3 cycles between bits 2 and 3. Required: a single y_out pulse 1 cycle after bit 5.
  - Assert rst after bit 3 of 10101, then continue with bits 0,1. Required: no match.
- Runtime pattern load:
  - Send 1,1,0, then pat_load=1 with pat_in=01101 and d_in=1 on the same edge. Required: that bit is discarded.
  - Then send 01101. Required: a y_out pulse and pat_cur=01101.
  - Then rst. Required: pat_cur=10101.
- Counter saturation and clear: CNT_W=2, OVERLAP=1, PATTERN=11, ones stream for 6 cycles. Required: match_cnt goes 1,2,3,3,3; y_out is high on 5 consecutive cycles. Then cnt_clr coincident with a match. Required: match_cnt=1.
- Wide pattern: PAT_W=16, PATTERN=16'hA5C3, 16-bit random prefix then A5C3. Required: exactly 1 pulse, except where the prefix itself contains A5C3 across the boundary (checked against a scoreboard model).
